video_fx_mux: RTL and testbench
===============================

// Module: video_fx_mux
// PURPOSE
//  Registered pixel-stage that sits directly downstream of the negative/positive inverter.
//  It takes both the raw pixel and the inverted pixel for the same cycle.
//  It selects full-frame effect, bypass, or a split-screen (left/right half) mix.
//  Timing is re-aligned to the pixel clock; the line width is measured automatically.
//  Mode changes take effect only on frame boundaries, so a frame never tears.
// PARAMETERS
//  CNT_W     12  column counter / line-width width (max width 2^CNT_W-1)
//  VSYNC_POL 1   active level of i_VSYNC (1 = active-high)
// PORTS
//  i_clk        in   1       pixel clock
//  i_rstn       in   1       synchronous reset, active-low
//  i_VDE        in   1       video data enable, aligned with both pixel inputs
//  i_HSYNC      in   1       horizontal sync, passed through
//  i_VSYNC      in   1       vertical sync, passed through; frame boundary source
//  i_rawPixel   in   24      unprocessed pixel {R,G,B}
//  i_fxPixel    in   24      inverted pixel from upstream effect stage {R,G,B}
//  i_mode       in   2       00 bypass, 01 full fx, 10 fx-left/raw-right, 11 raw-left/fx-right
//  o_VDE        out  1       delayed i_VDE
//  o_HSYNC      out  1       delayed i_HSYNC
//  o_VSYNC      out  1       delayed i_VSYNC
//  o_pixelData  out  24      selected pixel; 0 whenever o_VDE=0
//  o_lineWidth  out  CNT_W   last measured active pixels per line
//  o_locked     out  1       1 while FSM is in S_RUN
// BEHAVIOUR
//  Reset (i_rstn=0 at a rising edge)
//   - All outputs are 0, the FSM is in S_WAIT_VS, and the active mode is 00.
//   - The column counter, width register and width_valid are all 0.
//   - Reset mid-line takes effect on the next edge; no partial state survives.
//  Latency: fixed 2 cycles for VDE, HSYNC, VSYNC and pixel.
//   - Stage 1 registers the inputs and the column index.
//   - Stage 2 registers the selected pixel.
//  Column counter x
//   - x increments each cycle i_VDE=1; the first active pixel has x=0.
//   - x saturates at 2^CNT_W-1.
//   - On the VDE falling edge (i_VDE=0, previous=1): line_len = x, then x clears.
//  Width measurement
//   - In S_MEASURE, each line end sets width = line_len and width_valid = 1.
//   - In S_RUN, a line_len differing from width forces S_MEASURE.
//     On that transition, width is updated and width_valid stays 1.
//   - o_lineWidth = width.
//  Frame edge: the cycle where i_VSYNC goes to VSYNC_POL from the opposite level.
//  FSM
//   - S_WAIT_VS -> S_MEASURE on frame edge.
//     While in S_WAIT_VS, o_pixelData is forced 0.
//   - S_MEASURE -> S_RUN on frame edge if width_valid=1; otherwise it stays.
//     While in S_MEASURE, pixels are bypassed (raw).
//   - S_RUN -> S_MEASURE on a width mismatch (resolution change).
//     Raw output applies from the next line.
//  Mode latch
//   - i_mode is sampled into the active mode only on a frame edge, in any state.
//   - i_mode changes between frame edges are ignored.
//  Selection (S_RUN only), with half = width>>1 (odd width: extra pixel goes right)
//   - 00: raw.
//   - 01: fx.
//   - 10: fx if x<half, else raw.
//   - 11: raw if x<half, else fx.
//  Simultaneous events
//   - Frame edge in the same cycle as a line end: width update happens first.
//     The FSM then evaluates with the updated width_valid.
//   - A mismatch in the same cycle as a frame edge: mismatch wins (-> S_MEASURE).
//  i_HSYNC has no effect on state; it is delayed only.
// TESTING
//  1. Reset, then 3 frames of 8-px lines, mode 01, raw=0x102030, fx=0xEFDFCF:
//     - frame 1 output is 0.
//     - frame 2 output is raw, with o_lineWidth=8.
//     - frame 3 output is 0xEFDFCF, with o_locked=1.
//     - The 2-cycle latency is checked on VDE, HSYNC and VSYNC.
//  2. Locked, mode 10, width 8: x0..3 output fx, x4..7 output raw.
//     Width 7: x0..2 fx, x3..6 raw. Mode 11 gives the mirror image.
//  3. Toggle i_mode 01->00 mid-frame: the current frame stays fx.
//     Bypass starts exactly 2 cycles after the next frame edge.
//  4. Locked at width 8, then a 10-px line arrives:
//     - o_locked drops and o_lineWidth=10.
//     - Subsequent lines are raw.
//     - Lock returns after the next frame edge.
//  5. Assert i_rstn=0 mid-line in S_RUN:
//     - The next cycle shows all outputs 0 and o_lineWidth=0.
//     - The FSM re-enters S_WAIT_VS and needs 2 frame edges to relock.
//  6. VSYNC_POL=0 build: frame edges are detected on the falling i_VSYNC.
//     Tests 1-2 pass unchanged.

Source files
------------

// File: rtl/video_fx_mux.sv
// Two-stage pixel mux that picks raw, inverted or split-screen output per frame,
// measuring the active line width on the fly so the split point tracks resolution.
module video_fx_mux #(
  parameter int CNT_W     = 12,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_VDE,
  input  logic             i_HSYNC,
  input  logic             i_VSYNC,
  input  logic [23:0]      i_rawPixel,
  input  logic [23:0]      i_fxPixel,
  input  logic [1:0]       i_mode,
  output logic             o_VDE,
  output logic             o_HSYNC,
  output logic             o_VSYNC,
  output logic [23:0]      o_pixelData,
  output logic [CNT_W-1:0] o_lineWidth,
  output logic             o_locked
);

  typedef enum logic [1:0] {
    S_WAIT_VS,
    S_MEASURE,
    S_RUN
  } stateT;

  localparam logic [CNT_W-1:0] X_MAX = '1;

  stateT            r_state;
  stateT            w_stateNext;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_xPix;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] w_widthNext;
  logic             r_widthValid;
  logic             w_validNext;
  logic [1:0]       r_mode;
  logic             r_vsPrev;

  logic             r_vde1;
  logic             r_hs1;
  logic             r_vs1;
  logic [23:0]      r_raw1;
  logic [23:0]      r_fx1;

  logic             r_vde2;
  logic             r_hs2;
  logic             r_vs2;
  logic [23:0]      r_pix2;

  logic             w_lineEnd;
  logic             w_frameEdge;
  logic [CNT_W-1:0] w_half;
  logic             w_left;
  logic             w_useFx;
  logic [23:0]      w_pixSel;

  assign w_lineEnd   = !i_VDE && r_vde1;
  // r_vsPrev resets to the active level so a sync already asserted at reset is not a frame edge.
  assign w_frameEdge = (i_VSYNC == VSYNC_POL) && (r_vsPrev != VSYNC_POL);
  assign w_half      = r_width >> 1;
  assign w_left      = r_xPix < w_half;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_x      <= '0;
      r_vsPrev <= VSYNC_POL;
      r_mode   <= 2'b00;
    end else begin
      r_vsPrev <= i_VSYNC;
      if (i_VDE) begin
        if (r_x != X_MAX) begin
          r_x <= r_x + CNT_W'(1);
        end
      end else begin
        r_x <= '0;
      end
      if (w_frameEdge) begin
        r_mode <= i_mode;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= S_WAIT_VS;
      r_width      <= '0;
      r_widthValid <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_width      <= w_widthNext;
      r_widthValid <= w_validNext;
    end
  end

  // A line end is folded into the width before the frame-edge decision looks at width_valid.
  always_comb begin
    w_stateNext = r_state;
    w_widthNext = r_width;
    w_validNext = r_widthValid;
    case (r_state)
      S_WAIT_VS: begin
        if (w_frameEdge) begin
          w_stateNext = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (w_lineEnd) begin
          w_widthNext = r_x;
          w_validNext = 1'b1;
        end
        if (w_frameEdge && w_validNext) begin
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        if (w_lineEnd && (r_x != r_width)) begin
          w_stateNext = S_MEASURE;
          w_widthNext = r_x;
        end
      end
      default: begin
        w_stateNext = S_WAIT_VS;
      end
    endcase
  end

  always_comb begin
    w_useFx = 1'b0;
    case (r_mode)
      2'b00:   w_useFx = 1'b0;
      2'b01:   w_useFx = 1'b1;
      2'b10:   w_useFx = w_left;
      default: w_useFx = !w_left;
    endcase
  end

  always_comb begin
    w_pixSel = '0;
    if (r_vde1) begin
      case (r_state)
        S_MEASURE: w_pixSel = r_raw1;
        S_RUN:     w_pixSel = w_useFx ? r_fx1 : r_raw1;
        default:   w_pixSel = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_vde1 <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
      r_raw1 <= '0;
      r_fx1  <= '0;
      r_xPix <= '0;
      r_vde2 <= 1'b0;
      r_hs2  <= 1'b0;
      r_vs2  <= 1'b0;
      r_pix2 <= '0;
    end else begin
      r_vde1 <= i_VDE;
      r_hs1  <= i_HSYNC;
      r_vs1  <= i_VSYNC;
      r_raw1 <= i_rawPixel;
      r_fx1  <= i_fxPixel;
      r_xPix <= r_x;
      r_vde2 <= r_vde1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_pix2 <= w_pixSel;
    end
  end

  assign o_VDE       = r_vde2;
  assign o_HSYNC     = r_hs2;
  assign o_VSYNC     = r_vs2;
  assign o_pixelData = r_pix2;
  assign o_lineWidth = r_width;
  assign o_locked    = (r_state == S_RUN);

endmodule

// File: tb/tb_video_fx_mux.sv
// Bench for video_fx_mux: an active-high and an active-low VSYNC build run the same
// directed line/frame table side by side, with expected outputs delayed two cycles.
module tb_video_fx_mux;

  localparam logic [23:0] RAW = 24'h102030;
  localparam logic [23:0] FX  = 24'hEFDFCF;

  typedef struct {
    logic        vde;
    logic        hs;
    logic        vsH;
    logic        vsL;
    logic [23:0] pix;
    bit          chk;
  } expT;

  typedef struct {
    bit          isVs;
    int          width;
    logic [1:0]  mode;
    logic [15:0] fxMask;
    bit          zero;
    int          expW;
    bit          expL;
  } vecT;

  logic        clk = 1'b0;
  logic        rstn;
  logic        vde;
  logic        hs;
  logic        vs;
  logic        vsN;
  logic [23:0] raw;
  logic [23:0] fx;
  logic [1:0]  mode;

  logic        vdeH, hsH, vsOutH, lockH;
  logic [23:0] pixH;
  logic [11:0] widthH;
  logic        vdeL, hsL, vsOutL, lockL;
  logic [23:0] pixL;
  logic [11:0] widthL;

  expT d1;
  expT d2;
  vecT vecs[$];
  int  nChecks = 0;
  int  nFail   = 0;

  always #5 clk = ~clk;
  assign vsN = ~vs;

  video_fx_mux #(.CNT_W(12), .VSYNC_POL(1'b1)) dutH (
    .i_clk(clk), .i_rstn(rstn), .i_VDE(vde), .i_HSYNC(hs), .i_VSYNC(vs),
    .i_rawPixel(raw), .i_fxPixel(fx), .i_mode(mode),
    .o_VDE(vdeH), .o_HSYNC(hsH), .o_VSYNC(vsOutH), .o_pixelData(pixH),
    .o_lineWidth(widthH), .o_locked(lockH)
  );

  video_fx_mux #(.CNT_W(12), .VSYNC_POL(1'b0)) dutL (
    .i_clk(clk), .i_rstn(rstn), .i_VDE(vde), .i_HSYNC(hs), .i_VSYNC(vsN),
    .i_rawPixel(raw), .i_fxPixel(fx), .i_mode(mode),
    .o_VDE(vdeL), .o_HSYNC(hsL), .o_VSYNC(vsOutL), .o_pixelData(pixL),
    .o_lineWidth(widthL), .o_locked(lockL)
  );

  function automatic expT mkExp(logic v, logic h, logic sH, logic sL, logic [23:0] p, bit c);
    expT e;
    e.vde = v;
    e.hs  = h;
    e.vsH = sH;
    e.vsL = sL;
    e.pix = p;
    e.chk = c;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both builds' streaming outputs against one delayed expectation.
  task automatic checkOutput(input expT e);
    check("H vde",   {31'd0, vdeH},   {31'd0, e.vde});
    check("H hsync", {31'd0, hsH},    {31'd0, e.hs});
    check("H vsync", {31'd0, vsOutH}, {31'd0, e.vsH});
    check("H pixel", {8'd0, pixH},    {8'd0, e.pix});
    check("L vde",   {31'd0, vdeL},   {31'd0, e.vde});
    check("L hsync", {31'd0, hsL},    {31'd0, e.hs});
    check("L vsync", {31'd0, vsOutL}, {31'd0, e.vsL});
    check("L pixel", {8'd0, pixL},    {8'd0, e.pix});
  endtask

  task automatic checkStatus(input string tag, input int w, input bit l);
    check($sformatf("%s H width", tag),  {20'd0, widthH}, w);
    check($sformatf("%s H locked", tag), {31'd0, lockH},  {31'd0, l});
    check($sformatf("%s L width", tag),  {20'd0, widthL}, w);
    check($sformatf("%s L locked", tag), {31'd0, lockL},  {31'd0, l});
  endtask

  // Drive one pixel-clock cycle; the pixel expected for it is checked two cycles later.
  task automatic applyStimulus(input logic v, input logic h, input logic s,
                               input logic [1:0] m, input logic [23:0] expPix);
    @(negedge clk);
    if (d2.chk) checkOutput(d2);
    d2   = d1;
    d1   = mkExp(v, h, s, ~s, expPix, 1'b1);
    rstn = 1'b1;
    vde  = v;
    hs   = h;
    vs   = s;
    mode = m;
    raw  = RAW;
    fx   = FX;
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    if (d2.chk) checkOutput(d2);
    d2   = mkExp(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
    d1   = mkExp(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput(d2);
    checkStatus(tag, 0, 1'b0);
    d2   = d1;
    d1   = mkExp(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b1);
    rstn = 1'b1;
    vde  = 1'b0;
    hs   = 1'b0;
    vs   = 1'b0;
  endtask

  task automatic pushLine(input int w, input logic [1:0] m, input logic [15:0] mask,
                          input bit z, input int ew, input bit el);
    vecT v;
    v.isVs = 1'b0; v.width = w; v.mode = m; v.fxMask = mask;
    v.zero = z;    v.expW = ew; v.expL = el;
    vecs.push_back(v);
  endtask

  task automatic pushVs(input logic [1:0] m, input int ew, input bit el);
    vecT v;
    v.isVs = 1'b1; v.width = 0; v.mode = m; v.fxMask = 16'h0;
    v.zero = 1'b1; v.expW = ew; v.expL = el;
    vecs.push_back(v);
  endtask

  task automatic runVec(input int i);
    vecT v;
    logic [23:0] e;
    v = vecs[i];
    if (v.isVs) begin
      applyStimulus(1'b0, 1'b0, 1'b1, v.mode, 24'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, v.mode, 24'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, v.mode, 24'h0);
    end else begin
      for (int x = 0; x < v.width; x++) begin
        e = v.zero ? 24'h0 : (v.fxMask[x] ? FX : RAW);
        applyStimulus(1'b1, 1'b0, 1'b0, v.mode, e);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, v.mode, 24'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, v.mode, 24'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, v.mode, 24'h0);
    end
    checkStatus($sformatf("v%0d", i), v.expW, v.expL);
  endtask

  initial begin
    rstn = 1'b0; vde = 1'b0; hs = 1'b0; vs = 1'b0;
    raw  = RAW;  fx  = FX;   mode = 2'b01;
    d1   = mkExp(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    d2   = d1;

    // Startup: frame 1 blanked, frame 2 measured raw, frame 3 locked fx.
    pushLine(8, 2'b01, 16'h0000, 1'b1, 0, 1'b0);
    pushLine(8, 2'b01, 16'h0000, 1'b1, 0, 1'b0);
    pushVs(2'b01, 0, 1'b0);
    pushLine(8, 2'b01, 16'h0000, 1'b0, 8, 1'b0);
    pushLine(8, 2'b01, 16'h0000, 1'b0, 8, 1'b0);
    pushVs(2'b01, 8, 1'b1);
    pushLine(8, 2'b01, 16'hFFFF, 1'b0, 8, 1'b1);
    pushLine(8, 2'b01, 16'hFFFF, 1'b0, 8, 1'b1);
    // Split screen, width 8 then 7 (the first 7-px line still uses the width-8 split).
    pushVs(2'b10, 8, 1'b1);
    pushLine(8, 2'b10, 16'h000F, 1'b0, 8, 1'b1);
    pushLine(8, 2'b10, 16'h000F, 1'b0, 8, 1'b1);
    pushLine(7, 2'b10, 16'h000F, 1'b0, 7, 1'b0);
    pushLine(7, 2'b10, 16'h0000, 1'b0, 7, 1'b0);
    pushVs(2'b10, 7, 1'b1);
    pushLine(7, 2'b10, 16'h0007, 1'b0, 7, 1'b1);
    pushVs(2'b11, 7, 1'b1);
    pushLine(7, 2'b11, 16'h0078, 1'b0, 7, 1'b1);
    pushLine(8, 2'b11, 16'h00F8, 1'b0, 8, 1'b0);
    pushVs(2'b11, 8, 1'b1);
    pushLine(8, 2'b11, 16'h00F0, 1'b0, 8, 1'b1);
    // Mode toggled mid-frame must not change the current frame.
    pushVs(2'b01, 8, 1'b1);
    pushLine(8, 2'b01, 16'hFFFF, 1'b0, 8, 1'b1);
    pushLine(8, 2'b00, 16'hFFFF, 1'b0, 8, 1'b1);
    // Resolution change to 10 px.
    pushVs(2'b01, 8, 1'b1);
    pushLine(8,  2'b01, 16'hFFFF, 1'b0, 8,  1'b1);
    pushLine(10, 2'b01, 16'hFFFF, 1'b0, 10, 1'b0);
    pushLine(10, 2'b01, 16'h0000, 1'b0, 10, 1'b0);
    pushVs(2'b01, 10, 1'b1);
    pushLine(10, 2'b01, 16'hFFFF, 1'b0, 10, 1'b1);
    // After the mid-line reset: two frame edges to relock.
    pushLine(10, 2'b01, 16'h0000, 1'b1, 0,  1'b0);
    pushVs(2'b01, 0, 1'b0);
    pushLine(10, 2'b01, 16'h0000, 1'b0, 10, 1'b0);
    pushVs(2'b01, 10, 1'b1);
    pushLine(10, 2'b01, 16'hFFFF, 1'b0, 10, 1'b1);

    doReset("reset");
    for (int i = 0; i < 23; i++) runVec(i);

    // Frame edge lands on x4 with mode 00 pending: x0..3 stay fx, x4 onward is raw.
    for (int x = 0; x < 4; x++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, FX);
    for (int x = 4; x < 8; x++) applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, RAW);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 24'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 24'h0);
    checkStatus("edgeMidLine", 8, 1'b1);

    for (int i = 23; i < 29; i++) runVec(i);

    // Reset asserted partway through a locked line.
    for (int x = 0; x < 4; x++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b01, FX);
    doReset("midLineReset");

    for (int i = 29; i < vecs.size(); i++) runVec(i);

    applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
